ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device using the host-request sequence
// (inhibit, request-to-send, device-clocked frame) and checks the device
// acknowledge. Both PS/2 lines are driven open-drain through active-high
// pull-low enables; the top level builds the actual tri-state buffers.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,    // clock held low before request
    parameter int START_TIMEOUT  = 750000,  // release -> first device edge
    parameter int PACKET_TIMEOUT = 100000   // first device edge -> end of ack
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       o_done,
    output logic       o_error
);

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 1);
    localparam logic [19:0] PACKET_LAST  = 20'(PACKET_TIMEOUT - 1);

    // Faults do not linger in a separate error state: they return straight
    // to IDLE with the o_error pulse, so the pulse lands on IDLE entry just
    // like o_done does.
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        START,
        DATA,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t      state;
    logic [19:0] timer;
    logic [3:0]  bit_cnt;
    logic [9:0]  shreg;      // {stop, parity, data[7:0]}, shifted out LSB first

    logic [1:0]  clk_sync;
    logic [1:0]  data_sync;
    logic        clk_prev;
    logic        clk_s;
    logic        data_s;
    logic        clk_fall;

    assign clk_s    = clk_sync[1];
    assign data_s   = data_sync[1];
    assign clk_fall = clk_prev & ~clk_s;
    assign o_ready  = (state == IDLE);

    // Two-flop synchronizers on the raw pins plus the edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: synchronizers reset to 1 (idle bus level) so leaving reset
            // never manufactures a falling edge on the ps2 clock.
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            // NOTE: nonblocking assignments let every flop sample the old
            // value of its neighbour, which is what makes this a shift chain.
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_prev  <= clk_s;
        end
    end

    // Transmit sequencer: request, frame shifting, ack check and timeouts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            timer       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
        end else begin
            o_done  <= 1'b0;
            o_error <= 1'b0;
            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (i_valid) begin
                        shreg      <= {1'b1, ~^i_data, i_data};
                        timer      <= '0;
                        bit_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (timer == INHIBIT_LAST) begin
                        ps2_data_oe <= 1'b1;          // start bit
                        state       <= REQ;
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end

                REQ: begin
                    ps2_clk_oe <= 1'b0;               // hand the clock to the device
                    timer      <= '0;
                    state      <= START;
                end

                START: begin
                    if (clk_fall) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= {1'b1, shreg[9:1]};
                        bit_cnt     <= 4'd1;
                        timer       <= '0;            // packet timer starts here
                        state       <= DATA;
                    end else if (timer == START_LAST) begin
                        ps2_data_oe <= 1'b0;
                        o_error     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end

                DATA: begin
                    if (timer == PACKET_LAST) begin
                        ps2_data_oe <= 1'b0;
                        o_error     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 20'd1;
                        if (clk_fall) begin
                            // Edges 2..10 put out data1..7, parity, then stop.
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= {1'b1, shreg[9:1]};
                            bit_cnt     <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd9) begin
                                state <= ACK;
                            end
                        end
                    end
                end

                ACK: begin
                    ps2_data_oe <= 1'b0;
                    if (timer == PACKET_LAST) begin
                        o_error <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 20'd1;
                        if (clk_fall) begin
                            if (!data_s) begin
                                state <= WAIT_IDLE;
                            end else begin
                                o_error <= 1'b1;
                                state   <= IDLE;
                            end
                        end
                    end
                end

                WAIT_IDLE: begin
                    if (timer == PACKET_LAST) begin
                        o_error <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 20'd1;
                        if (clk_s && data_s) begin
                            o_done <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device drives the
// bus, expected frames and outcomes are queued at stimulus time and checked
// by independent monitor processes.
module tb_ps2_host_tx;

    localparam int INHIBIT = 10;
    localparam int START_TO = 50;
    localparam int PACKET_TO = 2000;
    localparam int HALF = 20;            // device clock half period, cycles

    typedef enum int {DEV_NORMAL, DEV_NACK, DEV_SILENT, DEV_STALL, DEV_ABORT} dev_mode_e;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       o_done;
    logic       o_error;
    logic       ps2_clk_pin;
    logic       ps2_data_pin;

    logic       dev_clk_low;
    logic       dev_data_low;
    logic       dev_busy;
    logic       abort_flag;
    dev_mode_e  dev_mode;

    int vectors;
    int miscompares;
    bit ready_chk;

    bit         exp_q[$];                // 1 = done expected, 0 = error expected
    logic [9:0] frame_q[$];              // expected {stop, parity, data}

    // Wired-AND open-drain bus with pull-ups.
    assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .START_TIMEOUT (START_TO),
        .PACKET_TIMEOUT(PACKET_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .ps2_clk_i  (ps2_clk_pin),
        .ps2_data_i (ps2_data_pin),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .o_done     (o_done),
        .o_error    (o_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: data LSB first, odd parity over the byte, stop = 1.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    // Outcome monitor: every done/error pulse is matched against the queue.
    initial begin
        bit e;
        ready_chk = 0;
        forever begin
            @(negedge clk);
            if (ready_chk) begin
                check("ready_after_pulse", o_ready, 1);
                ready_chk = 0;
            end
            if (o_done || o_error) begin
                check("done_error_exclusive", o_done & o_error, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {o_done, o_error}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("outcome_done", o_done, e);
                end
                check("lines_released_at_pulse", {ps2_clk_oe, ps2_data_oe}, 0);
                ready_chk = 1;
            end
        end
    end

    // Behavioural PS/2 device: answers a host request by clocking 11 edges,
    // samples each host bit on the rising clock, acks on edge 11 if asked.
    initial begin
        logic [9:0] cap;
        dev_clk_low  = 0;
        dev_data_low = 0;
        dev_busy     = 0;
        abort_flag   = 0;
        cap          = '0;
        forever begin
            @(negedge clk);
            if (rst_n && ps2_clk_pin && !ps2_data_pin && dev_mode != DEV_SILENT) begin
                dev_busy = 1;
                repeat (10) @(negedge clk);
                for (int k = 1; k <= 11; k++) begin
                    if (k == 11) begin
                        if (dev_mode == DEV_NORMAL) dev_data_low = 1;
                        repeat (5) @(negedge clk);
                    end
                    dev_clk_low = 1;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 0;
                    if (k <= 10) cap[k-1] = ps2_data_pin;
                    if (k == 10 && (dev_mode == DEV_NORMAL || dev_mode == DEV_NACK)) begin
                        if (frame_q.size() == 0) check("unexpected_frame", 1, 0);
                        else check("frame_bits", cap, frame_q.pop_front());
                    end
                    if (dev_mode == DEV_ABORT && k == 4) begin
                        abort_flag = 1;
                        break;
                    end
                    if (dev_mode == DEV_STALL && k == 5) break;
                    repeat (HALF) @(negedge clk);
                end
                dev_data_low = 0;
                while (!ps2_data_pin) @(negedge clk);
                dev_busy = 0;
            end
        end
    end

    // Issue one byte; also measures the inhibit/request timing on the way.
    task automatic send(input logic [7:0] b, input dev_mode_e m);
        int n;
        int t;
        int first_d;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", o_ready, 1);
        dev_mode = m;
        case (m)
            DEV_NORMAL: begin exp_q.push_back(1'b1); frame_q.push_back(ref_frame(b)); end
            DEV_NACK:   begin exp_q.push_back(1'b0); frame_q.push_back(ref_frame(b)); end
            DEV_SILENT: exp_q.push_back(1'b0);
            DEV_STALL:  exp_q.push_back(1'b0);
            default: ;
        endcase
        i_data  = b;
        i_valid = 1;
        @(negedge clk);
        i_valid = 0;
        i_data  = 8'($urandom);          // must not disturb the latched frame
        t = 1;
        first_d = -1;
        while (ps2_clk_oe && t < 200) begin
            if (ps2_data_oe && first_d < 0) first_d = t;
            @(negedge clk);
            t++;
        end
        check("clk_oe_width", t - 1, INHIBIT + 1);
        check("data_oe_offset", first_d - 1, INHIBIT);
    endtask

    task automatic wait_complete(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || frame_q.size() != 0 || dev_busy || !o_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_complete"}, (n < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c;
        logic [7:0] b;
        vectors     = 0;
        miscompares = 0;
        dev_mode    = DEV_NORMAL;
        rst_n       = 0;
        i_valid     = 0;
        i_data      = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", o_ready, 1);
        check("reset_clk_oe", ps2_clk_oe, 0);
        check("reset_data_oe", ps2_data_oe, 0);
        check("reset_done", o_done, 0);
        check("reset_error", o_error, 0);
        rst_n = 1;
        repeat (3) @(negedge clk);

        // Command byte with ack.
        send(8'hED, DEV_NORMAL);
        wait_complete("send_ed", 3000);

        // Consecutive extremes.
        send(8'h00, DEV_NORMAL);
        wait_complete("send_00", 3000);
        send(8'hFF, DEV_NORMAL);
        wait_complete("send_ff", 3000);

        // Device never acks.
        send(8'($urandom), DEV_NACK);
        wait_complete("nack", 3000);

        // Device never clocks; requests during the wait must be ignored.
        send(8'($urandom), DEV_SILENT);
        c = 0;
        while (!o_error && c < START_TO + 20) begin
            if (c < START_TO - 5) begin
                i_valid = 1;
                i_data  = 8'($urandom);
            end else begin
                i_valid = 0;
            end
            @(negedge clk);
            c++;
        end
        i_valid = 0;
        check("start_timeout_cycles", c, START_TO);
        @(negedge clk);
        check("no_accept_after_timeout", ps2_clk_oe, 0);
        wait_complete("silent", 500);

        // Device stops clocking mid-frame.
        send(8'($urandom), DEV_STALL);
        wait_complete("stall", PACKET_TO + 3000);

        // Reset after edge 4 while the host pulls data low for bit3.
        b = 8'($urandom) & 8'hF7;
        send(b, DEV_ABORT);
        c = 0;
        while (!abort_flag && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("abort_reached_edge4", abort_flag, 1);
        @(negedge clk);
        check("abort_data_oe_before_reset", ps2_data_oe, 1);
        rst_n = 0;
        #1;
        check("abort_clk_oe", ps2_clk_oe, 0);
        check("abort_data_oe", ps2_data_oe, 0);
        check("abort_ready", o_ready, 1);
        repeat (3) @(negedge clk);
        check("abort_no_pulse", {o_done, o_error}, 0);
        rst_n = 1;
        abort_flag = 0;
        wait_complete("abort", 500);
        send(8'hF4, DEV_NORMAL);
        wait_complete("send_f4", 3000);

        // Randomized traffic.
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom), ($urandom_range(3) == 0) ? DEV_NACK : DEV_NORMAL);
            wait_complete("random", 3000);
        end

        check("outcome_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop if something hangs.
    initial begin
        repeat (80000) @(posedge clk);
        miscompares++;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
